// File: rtl/llander_pkg.sv
// Shared constants and types for the Lunar Lander player-control stage.
package llander_pkg;

  localparam logic [7:0] THRUST_MAX_C = 8'd254;
  localparam int unsigned TICK_DIV_C = 98425;

  localparam int TURN_ON_C  = 64;
  localparam int TURN_OFF_C = 48;
  localparam int SLEW_STEP_C = 16;

  typedef enum logic {
    TM_ANALOG = 1'b0,
    TM_DPAD   = 1'b1
  } thrust_mode_e;

endpackage

// File: rtl/llander_thrust_ctrl_if.sv
// Player-control bus between the HPS input bridge and the thrust controller.
interface llander_thrust_ctrl_if;
  import llander_pkg::*;

  // No valid/ready handshake: every input is a level sampled on each clk_25
  // edge, and every output is a registered level that is valid every cycle.
  logic [7:0]   analog_x;
  logic [7:0]   analog_y;
  logic         up_req;
  logic         down_req;
  logic         mode_dpad;
  logic [7:0]   thrust;
  logic         turn_l;
  logic         turn_r;
  thrust_mode_e mode_state;

  modport master (
    output analog_x, analog_y, up_req, down_req, mode_dpad,
    input  thrust, turn_l, turn_r, mode_state
  );

  modport slave (
    input  analog_x, analog_y, up_req, down_req, mode_dpad,
    output thrust, turn_l, turn_r, mode_state
  );

endinterface

// File: rtl/llander_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks (count DIV-1).
module llander_tick_gen #(
  parameter int unsigned DIV = llander_pkg::TICK_DIV_C
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/llander_thrust_ctrl.sv
// Stick/D-pad conditioning into the core's THRUST byte and turn requests.
// Optional analog slew limiter enabled by defining LLANDER_THRUST_SLEW_EN.
module llander_thrust_ctrl
  import llander_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_C,
  parameter logic [7:0]  THRUST_MAX = THRUST_MAX_C,
  parameter int          TURN_ON    = TURN_ON_C,
  parameter int          TURN_OFF   = TURN_OFF_C
`ifdef LLANDER_THRUST_SLEW_EN
  ,
  parameter int          SLEW_STEP  = SLEW_STEP_C
`endif
) (
  input  logic                  clk_25,
  input  logic                  RESET_L,
  llander_thrust_ctrl_if.slave  bus
);

  localparam logic signed [8:0] ON_P  = 9'(TURN_ON);
  localparam logic signed [8:0] ON_N  = 9'(-TURN_ON);
  localparam logic signed [8:0] OFF_P = 9'(TURN_OFF);
  localparam logic signed [8:0] OFF_N = 9'(-TURN_OFF);

  // ---------------- input registers ----------------
  logic signed [7:0] x_q;
  logic signed [7:0] y_q;
  logic              up_q;
  logic              dn_q;
  logic              mode_in_q;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      x_q       <= '0;
      y_q       <= '0;
      up_q      <= 1'b0;
      dn_q      <= 1'b0;
      mode_in_q <= 1'b0;
    end else begin
      x_q       <= bus.analog_x;
      y_q       <= bus.analog_y;
      up_q      <= bus.up_req;
      dn_q      <= bus.down_req;
      mode_in_q <= bus.mode_dpad;
    end
  end

  // ---------------- analog target ----------------
  // 127 - y spans 0..255 for any 8-bit y, so only the top needs clamping.
  logic signed [8:0] y_s;
  logic signed [8:0] target_s;
  logic [7:0]        target;

  assign y_s      = {y_q[7], y_q};
  assign target_s = 9'sd127 - y_s;
  assign target   = (target_s > $signed({1'b0, THRUST_MAX})) ? THRUST_MAX
                                                             : target_s[7:0];

  // ---------------- tick prescaler ----------------
  logic tick;

  llander_tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk_25),
    .rst_n (RESET_L),
    .tick  (tick)
  );

  // ---------------- mode FSM ----------------
  thrust_mode_e mode_q;
  thrust_mode_e mode_d;
  logic         to_dpad;
  logic         to_analog;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      mode_q <= TM_ANALOG;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d    = mode_q;
    to_dpad   = 1'b0;
    to_analog = 1'b0;
    case (mode_q)
      TM_ANALOG: begin
        if (mode_in_q) begin
          mode_d  = TM_DPAD;
          to_dpad = 1'b1;
        end
      end
      TM_DPAD: begin
        if (!mode_in_q) begin
          mode_d    = TM_ANALOG;
          to_analog = 1'b1;
        end
      end
      default: mode_d = TM_ANALOG;
    endcase
  end

  // ---------------- ramp integrator ----------------
  // Seeding from the analog target on entry to D-pad mode takes priority
  // over a coincident tick so the hand-over is bumpless.
  logic [7:0] ramp_q;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      ramp_q <= '0;
    end else if (to_dpad) begin
      ramp_q <= target;
    end else if (tick) begin
      if (up_q && !dn_q && (ramp_q < THRUST_MAX)) begin
        ramp_q <= ramp_q + 8'd1;
      end else if (dn_q && !up_q && (ramp_q != 8'd0)) begin
        ramp_q <= ramp_q - 8'd1;
      end
    end
  end

  // ---------------- analog path ----------------
  logic [7:0] analog_path;

`ifdef LLANDER_THRUST_SLEW_EN
  localparam logic signed [9:0] STEP_P = 10'(SLEW_STEP);
  localparam logic signed [9:0] STEP_N = 10'(-SLEW_STEP);
  localparam logic [7:0]        STEP_U = 8'(SLEW_STEP);

  logic [7:0]        slew_q;
  logic signed [9:0] slew_diff;

  assign slew_diff = $signed({2'b00, target}) - $signed({2'b00, slew_q});

  // Seeded from the ramp when leaving D-pad mode so the output cannot jump.
  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      slew_q <= '0;
    end else if (to_analog) begin
      slew_q <= ramp_q;
    end else if (tick) begin
      if (slew_diff > STEP_P) begin
        slew_q <= slew_q + STEP_U;
      end else if (slew_diff < STEP_N) begin
        slew_q <= slew_q - STEP_U;
      end else begin
        slew_q <= target;
      end
    end
  end

  assign analog_path = slew_q;
`else
  assign analog_path = target;
`endif

  // ---------------- thrust output ----------------
  logic [7:0] thrust_q;

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      thrust_q <= '0;
    end else if (mode_q == TM_ANALOG) begin
      thrust_q <= analog_path;
    end else begin
      thrust_q <= ramp_q;
    end
  end

  // ---------------- turn hysteresis ----------------
  // 9-bit compare keeps x = -128 well-defined; set and clear bands are
  // disjoint across sides, so left and right can never both be asserted.
  logic signed [8:0] x_s;
  logic              turn_l_q;
  logic              turn_r_q;

  assign x_s = {x_q[7], x_q};

  always_ff @(posedge clk_25 or negedge RESET_L) begin
    if (!RESET_L) begin
      turn_l_q <= 1'b0;
      turn_r_q <= 1'b0;
    end else begin
      if (!turn_l_q) begin
        turn_l_q <= (x_s < ON_N);
      end else begin
        turn_l_q <= (x_s < OFF_N);
      end
      if (!turn_r_q) begin
        turn_r_q <= (x_s > ON_P);
      end else begin
        turn_r_q <= (x_s > OFF_P);
      end
    end
  end

  assign bus.thrust     = thrust_q;
  assign bus.turn_l     = turn_l_q;
  assign bus.turn_r     = turn_r_q;
  assign bus.mode_state = mode_q;

endmodule

// File: doc/llander_thrust_ctrl.md
Name: llander_thrust_ctrl

Overview:
Player-control conditioning stage placed directly upstream of the Lunar Lander game core.
- Converts the HPS analog stick, D-pad and keyboard bits into the core's 8-bit THRUST value and active-high turn-left/turn-right requests.
- Thrust comes from one of two sources: analog (absolute stick position) or digital (ramp integrator).
- Mode switching is bumpless. Turn requests from the stick use hysteresis.
- The top level inverts the turn outputs and ORs them with the buttons to form the active-low core inputs.

Parameters:
- TICK_DIV, 98425: clk_25 cycles per ramp tick (0→254 in about 1 s at 25 MHz).
- THRUST_MAX, 254: thrust ceiling. The core never expects 255.
- TURN_ON, 64: stick X magnitude that asserts a turn request (strictly greater than).
- TURN_OFF, 48: stick X magnitude at or below which the turn request drops.
- SLEW_STEP, 16: maximum analog-path change per tick (optional feature only).

Ports:
- clk_25, in, 1: system clock.
- RESET_L, in, 1: reset, asynchronous, active-low.
- analog_x, in, 8: signed stick X. Negative is left.
- analog_y, in, 8: signed stick Y. Negative is up.
- up_req, in, 1: increase thrust (D-pad OR keyboard, pre-ORed).
- down_req, in, 1: decrease thrust.
- mode_dpad, in, 1: 0 = analog source, 1 = ramp source (OSD status bit).
- thrust, out, 8: unsigned thrust to core, range 0..THRUST_MAX.
- turn_l, out, 1: stick-derived turn-left request, active-high.
- turn_r, out, 1: stick-derived turn-right request, active-high.

Behaviour:
- Reset (async assert, sync release): thrust=0, turn_l=0, turn_r=0, ramp=0, tick counter=0, mode_q=0, input registers=0.
- Input stage:
  - analog_x, analog_y, up_req, down_req and mode_dpad are registered once.
  - All further logic uses the registered copies.
- Analog mapping:
  - target = 127 − y, computed in 9-bit signed.
  - y=−128 → 255, clamped to THRUST_MAX. y=0 → 127. y=127 → 0.
  - Result is never negative; no lower clamp is needed.
- Tick prescaler:
  - Counts 0..TICK_DIV−1 and wraps.
  - tick is a 1-cycle pulse when count = TICK_DIV−1.
  - Free-runs in both modes.
- Ramp register (8-bit), updated only on tick:
  - up only: +1, saturating at THRUST_MAX.
  - down only: −1, saturating at 0.
  - Both or neither: hold.
- Mode FSM, states ANALOG and DPAD:
  - mode_q tracks the registered mode_dpad.
  - On the ANALOG→DPAD edge, ramp is loaded with the current analog target in that cycle. This load wins over a coincident tick step.
  - On the DPAD→ANALOG edge, ramp holds its value; the output follows the analog target from the next cycle.
- Output:
  - thrust is registered: ANALOG ? analog_path : ramp.
  - Latency from analog_y pin to thrust is 2 clk_25 cycles.
- Turn hysteresis, per side:
  - turn_l sets when x < −TURN_ON and clears when x ≥ −TURN_OFF.
  - turn_r sets when x > TURN_ON and clears when x ≤ TURN_OFF.
  - Both can never be 1 together.
  - x = −128 is valid: it asserts turn_l with no overflow. Compare in 9-bit signed.
- Reset mid-operation: all state returns to reset values immediately; the output is 0 until the input pipeline refills.

Optional Feature:
- Macro: LLANDER_THRUST_SLEW_EN.
- Defined:
  - analog_path is a register that moves toward target by at most SLEW_STEP per tick.
  - It lands exactly on target when the distance is ≤ SLEW_STEP; there is no overshoot.
  - On the DPAD→ANALOG edge it is seeded from ramp, so there is no jump.
- Undefined:
  - analog_path = target combinationally, with no slew register.
  - SLEW_STEP is unused.

Decomposition:
- Shared package llander_pkg holds:
  - THRUST_MAX_C (8'd254) and the default TICK_DIV constant.
  - The mode enum typedef thrust_mode_e {TM_ANALOG, TM_DPAD}.
- One natural sub-module, llander_tick_gen: a parameterised prescaler producing the tick pulse. It is reusable for the difficulty-overlay timeout.
- Turn hysteresis and ramp stay inline.

Test Plan:
1. Reset release, mode_dpad=0, analog_y=8'h80 (−128) → thrust=254 two cycles after the input settles; never 255.
2. mode_dpad=1, up_req held, TICK_DIV=4 → thrust +1 every 4 cycles from 0 and saturates at 254. Then up+down together → held constant for 10 ticks.
3. Analog y=0 (thrust 127), then switch mode_dpad 0→1 → ramp seeded to 127. Next tick with down_req → 126; no 0-glitch on thrust.
4. Sweep analog_x −128→+127→−128 → turn_l high for x<−64 and low once x≥−48. turn_r mirrors this. Never both high; x=−60 after x=−70 keeps turn_l=1.
5. Assert RESET_L=0 mid-ramp at thrust=200 → thrust, turn_l, turn_r go to 0 asynchronously, same cycle. After release, ramp restarts from 0.
6. With LLANDER_THRUST_SLEW_EN, SLEW_STEP=16, target step 0→127 → output 16, 32, …, 112, 127 on successive ticks. Without the macro → 127 after 2 cycles.
